sdram_host_arbiter: RTL and testbench

//  Shares the single-command SDRAM controller host port between NUM_PORTS requesters.

---
 rtl/sdram_host_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_host_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_arbiter.sv
`default_nettype none
// sdram_host_arbiter: round-robin sharing of the single-command SDRAM controller host port.
// One command in flight; enables are held until the controller shows busy.
module sdram_host_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int HADDR_WIDTH = 24,
    parameter int WDOG_WIDTH  = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req_valid,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*16-1:0]          req_wdata,
    output logic [NUM_PORTS-1:0]             req_ready,
    output logic [NUM_PORTS-1:0]             rsp_valid,
    output logic                             rsp_we,
    output logic [15:0]                      rsp_rdata,
    output logic                             err_timeout,
    output logic [HADDR_WIDTH-1:0]           wr_addr,
    output logic [15:0]                      wr_data,
    output logic                             wr_enable,
    output logic [HADDR_WIDTH-1:0]           rd_addr,
    output logic                             rd_enable,
    input  logic [15:0]                      rd_data,
    input  logic                             rd_ready,
    input  logic                             busy
);

    localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PW1 = PW + 1;
    localparam logic [WDOG_WIDTH-1:0] WDOG_PRE = {{(WDOG_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        WAIT_WR = 2'd3
    } state_t;

    state_t                  state_q;
    logic [PW-1:0]           rr_q;
    logic [PW-1:0]           owner_q;
    logic                    we_q;
    logic [HADDR_WIDTH-1:0]  addr_q;
    logic [15:0]             wdata_q;
    logic [WDOG_WIDTH-1:0]   wdog_q;
    logic                    wr_enable_q;
    logic                    rd_enable_q;
    logic [NUM_PORTS-1:0]    rsp_valid_q;
    logic                    rsp_we_q;
    logic [15:0]             rsp_rdata_q;
    logic                    err_q;

    logic                    grant_d;
    logic [PW-1:0]           winner_d;
    logic [PW-1:0]           rr_d;
    logic [PW1-1:0]          scan_d;

    // Search upward from the rotation pointer, wrapping at NUM_PORTS.
    always_comb begin
        grant_d  = 1'b0;
        winner_d = '0;
        scan_d   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_d = {1'b0, rr_q} + PW1'(k);
            if (scan_d >= PW1'(NUM_PORTS)) begin
                scan_d = scan_d - PW1'(NUM_PORTS);
            end
            if (!grant_d && req_valid[scan_d[PW-1:0]]) begin
                grant_d  = 1'b1;
                winner_d = scan_d[PW-1:0];
            end
        end
        rr_d = (winner_d == PW'(NUM_PORTS - 1)) ? '0 : winner_d + 1'b1;
    end

    assign req_ready   = (state_q == IDLE && grant_d) ? (NUM_PORTS'(1) << winner_d) : '0;
    assign wr_addr     = addr_q;
    assign rd_addr     = addr_q;
    assign wr_data     = wdata_q;
    assign wr_enable   = wr_enable_q;
    assign rd_enable   = rd_enable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_we      = rsp_we_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign err_timeout = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wdog_q      <= '0;
            wr_enable_q <= 1'b0;
            rd_enable_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= '0;

            // Watchdog saturates; the flag is sticky and the FSM keeps waiting.
            if (state_q == IDLE) begin
                wdog_q <= '0;
            end else if (wdog_q != '1) begin
                wdog_q <= wdog_q + 1'b1;
            end
            if (state_q != IDLE && wdog_q == WDOG_PRE) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q     <= winner_d;
                        we_q        <= req_we[winner_d];
                        addr_q      <= req_addr[winner_d*HADDR_WIDTH +: HADDR_WIDTH];
                        wdata_q     <= req_wdata[winner_d*16 +: 16];
                        rr_q        <= rr_d;
                        wr_enable_q <= req_we[winner_d];
                        rd_enable_q <= ~req_we[winner_d];
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (busy) begin
                        wr_enable_q <= 1'b0;
                        rd_enable_q <= 1'b0;
                        state_q     <= we_q ? WAIT_WR : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (rd_ready) begin
                        rsp_rdata_q <= rd_data;
                        rsp_valid_q <= NUM_PORTS'(1) << owner_q;
                        rsp_we_q    <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                WAIT_WR: begin
                    if (!busy) begin
                        rsp_valid_q <= NUM_PORTS'(1) << owner_q;
                        rsp_we_q    <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_host_arbiter.sv
`default_nettype none
// tb_sdram_host_arbiter: directed checks of arbitration, handshakes, watchdog and async reset.
module tb_sdram_host_arbiter;

    localparam int NP = 2;
    localparam int AW = 24;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_we;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*16-1:0]  req_wdata;
    logic [NP-1:0]     req_ready;
    logic [NP-1:0]     rsp_valid;
    logic              rsp_we;
    logic [15:0]       rsp_rdata;
    logic              err_timeout;
    logic [AW-1:0]     wr_addr;
    logic [15:0]       wr_data;
    logic              wr_enable;
    logic [AW-1:0]     rd_addr;
    logic              rd_enable;
    logic [15:0]       rd_data;
    logic              rd_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] mem [logic [23:0]];

    always #5 clk = ~clk;

    sdram_host_arbiter #(.NUM_PORTS(NP), .HADDR_WIDTH(AW), .WDOG_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .err_timeout(err_timeout), .wr_addr(wr_addr), .wr_data(wr_data), .wr_enable(wr_enable),
        .rd_addr(rd_addr), .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full command through a hand-driven controller; returns at the response cycle.
    task automatic cmd(input int p, input logic we, input logic [23:0] a, input logic [15:0] wd,
                       input int hold, input logic [1:0] vmask);
        logic [15:0] exp_rd;
        req_valid = vmask | (2'b01 << p);
        req_we[p] = we;
        req_addr[p*AW +: AW] = a;
        req_wdata[p*16 +: 16] = wd;
        #1 chk("grant", req_ready, 64'(1) << p);
        @(negedge clk);
        req_valid = vmask;
        #1;
        chk("en_wr", wr_enable, we);
        chk("en_rd", rd_enable, !we);
        chk("addr_wr", wr_addr, a);
        chk("addr_rd", rd_addr, a);
        if (we) chk("wdata", wr_data, wd);
        chk("ready_busy", req_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1 chk("en_hold", {wr_enable, rd_enable}, {we, !we});
        end
        busy = 1'b1;
        @(negedge clk);
        #1 chk("en_drop", {wr_enable, rd_enable}, 0);
        if (we) begin
            mem[a] = wd;
            busy = 1'b0;
            @(negedge clk);
            #1;
            chk("rsp_valid_w", rsp_valid, 64'(1) << p);
            chk("rsp_we_w", rsp_we, 1);
        end else begin
            exp_rd = mem.exists(a) ? mem[a] : 16'h0000;
            rd_data = exp_rd;
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
            busy = 1'b0;
            #1;
            chk("rsp_valid_r", rsp_valid, 64'(1) << p);
            chk("rsp_we_r", rsp_we, 0);
            chk("rsp_rdata", rsp_rdata, exp_rd);
        end
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1 chk("rsp_quiet", rsp_valid, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        rd_data = '0; rd_ready = 1'b0; busy = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_outs", {wr_enable, rd_enable, rsp_valid, rsp_we, err_timeout, req_ready}, 0);
        chk("rst_data", {wr_addr, rd_addr, wr_data, rsp_rdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then read back from the other port.
        cmd(0, 1'b1, 24'h012345, 16'hBEEF, 2, 2'b00);
        idle_gap(1);
        cmd(1, 1'b0, 24'h012345, 16'h0000, 2, 2'b00);
        idle_gap(1);

        // Both ports valid throughout: strict alternation 0,1,0,1.
        cmd(0, 1'b1, 24'h000100, 16'hA5A5, 0, 2'b11);
        cmd(1, 1'b0, 24'h000100, 16'h0000, 0, 2'b11);
        cmd(0, 1'b1, 24'h000200, 16'h5A5A, 1, 2'b11);
        cmd(1, 1'b0, 24'h000200, 16'h0000, 0, 2'b11);
        req_valid = '0;
        idle_gap(2);

        // Controller refreshing for a while before accepting.
        cmd(1, 1'b1, 24'h1ABCDE, 16'h1234, 8, 2'b00);
        idle_gap(3);
        cmd(0, 1'b0, 24'h1ABCDE, 16'h0000, 0, 2'b00);
        idle_gap(1);

        // Watchdog: rotation now points at port 1; busy never rises.
        req_valid = 2'b10; req_we[1] = 1'b1; req_addr[AW +: AW] = 24'h000ABC;
        #1 chk("wd_grant", req_ready, 2'b10);
        @(negedge clk);
        req_valid = '0;
        repeat (1020) @(negedge clk);
        #1;
        chk("wd_early", err_timeout, 0);
        chk("wd_en_held", wr_enable, 1);
        repeat (5) @(negedge clk);
        #1;
        chk("wd_set", err_timeout, 1);
        chk("wd_still_wait", wr_enable, 1);
        busy = 1'b1;
        @(negedge clk);
        busy = 1'b0;
        @(negedge clk);
        #1;
        chk("wd_rsp", rsp_valid, 2'b10);
        chk("wd_sticky", err_timeout, 1);
        idle_gap(2);
        chk("wd_sticky2", err_timeout, 1);
        rst_n = 1'b0;
        #1 chk("wd_clr", err_timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset while waiting for read data.
        req_valid = 2'b01; req_we[0] = 1'b0; req_addr[0 +: AW] = 24'h012345;
        #1 chk("ar_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = '0;
        #1 chk("ar_rden", rd_enable, 1);
        busy = 1'b1;
        @(negedge clk);
        #1 chk("ar_wait", rd_enable, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_outs", {wr_enable, rd_enable, rsp_valid, rsp_we, req_ready}, 0);
        chk("ar_addr", {wr_addr, rd_addr, wr_data}, 0);
        rd_data = 16'hFFFF;
        rd_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        busy = 1'b0;
        #1 chk("ar_no_rsp", rsp_valid, 0);
        idle_gap(3);
        chk("ar_rdata", rsp_rdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
